// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: FSM encoding
// and default timeout limit.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam int WAIT_LIMIT_DEFAULT = 255;
  localparam int WAIT_CNT_W         = 8;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination feeds the ID
// instruction. Register x0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] rs1_ID,
  input  logic [4:0] rs2_ID,
  input  logic       uses_rs2_ID,
  input  logic [4:0] rd_EX,
  input  logic       memread_EX,
  output logic       load_use
);

  assign load_use = memread_EX && (rd_EX != 5'd0) &&
                    ((rd_EX == rs1_ID) || (uses_rs2_ID && (rd_EX == rs2_ID)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: load-use stalls, branch flushes, data-memory wait FSM
// with timeout, and saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             uses_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             exmem_hold,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_LIMIT);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic mem_stall;
  logic run_eval;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect u_hazard (
    .rs1_ID      (rs1_ID),
    .rs2_ID      (rs2_ID),
    .uses_rs2_ID (uses_rs2_ID),
    .rd_EX       (rd_EX),
    .memread_EX  (memread_EX),
    .load_use    (load_use)
  );

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mem_stall   = 1'b0;
    run_eval    = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (dmem_req_MEM && !dmem_ready) begin
          mem_stall  = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          run_eval = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          mem_stall = 1'b1;
          if (wait_cnt_q == WAIT_LIM) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
          end
        end else begin
          // Access completes: this cycle behaves exactly like RUN
          state_d  = ST_RUN;
          run_eval = 1'b1;
        end
      end
      ST_ERROR: mem_stall = 1'b1;
      default:  state_d   = ST_RUN;
    endcase

    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    exmem_hold  = 1'b0;

    if (mem_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
    end else if (run_eval && branch_taken_EX) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (run_eval && load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end

    if (!pc_write && (state_q == ST_RUN || state_q == ST_MEM_WAIT))
      stall_cnt_d = sat_inc(stall_cnt_q);

    // Reset holds the pipeline frozen with bubbles in every stage register
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      exmem_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign err       = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short timeout and narrow counters
// so the timeout and saturation boundaries are reached quickly.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // Control vector order: pc_write, ifid_write, idex_write,
  // ifid_flush, idex_flush, memwb_flush, exmem_hold
  localparam logic [6:0] C_DEF = 7'b1110000;
  localparam logic [6:0] C_LU  = 7'b0010100;
  localparam logic [6:0] C_BR  = 7'b1111100;
  localparam logic [6:0] C_MS  = 7'b0000011;
  localparam logic [6:0] C_RST = 7'b0001110;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic uses_rs2_ID, memread_EX, branch_taken_EX, dmem_req_MEM, dmem_ready;
  logic pc_write, ifid_write, idex_write, ifid_flush, idex_flush, memwb_flush, exmem_hold;
  logic [1:0] state;
  logic err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.WAIT_LIMIT(4), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .uses_rs2_ID     (uses_rs2_ID),
    .rd_EX           (rd_EX),
    .memread_EX      (memread_EX),
    .branch_taken_EX (branch_taken_EX),
    .dmem_req_MEM    (dmem_req_MEM),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .exmem_hold      (exmem_hold),
    .state           (state),
    .err             (err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  wire [6:0] ctl = {pc_write, ifid_write, idex_write, ifid_flush,
                    idex_flush, memwb_flush, exmem_hold};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u2, input logic br,
                        input logic req, input logic rdy);
    memread_EX      = mr;
    rd_EX           = rd;
    rs1_ID          = r1;
    rs2_ID          = r2;
    uses_rs2_ID     = u2;
    branch_taken_EX = br;
    dmem_req_MEM    = req;
    dmem_ready      = rdy;
  endtask

  // Checks combinational controls mid-cycle, clocks once, checks registered state
  task automatic step(input string tag, input logic [6:0] ctl_exp, input logic [1:0] st_exp,
                      input int stall_exp, input int flush_exp, input logic err_exp);
    #1;
    chk({tag, ".ctl"}, 32'(ctl), 32'(ctl_exp));
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 32'(state), 32'(st_exp));
    chk({tag, ".stall"}, 32'(stall_cnt), 32'(stall_exp));
    chk({tag, ".flush"}, 32'(flush_cnt), 32'(flush_exp));
    chk({tag, ".err"}, 32'(err), 32'(err_exp));
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    step("reset", C_RST, 2'd0, 0, 0, 1'b0);

    rst_n = 1'b1;
    step("idle", C_DEF, 2'd0, 0, 0, 1'b0);

    set_in(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
    step("lu_rs1", C_LU, 2'd0, 1, 0, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("lu_once", C_DEF, 2'd0, 1, 0, 1'b0);
    set_in(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
    step("lu_rd0", C_DEF, 2'd0, 1, 0, 1'b0);
    set_in(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0);
    step("rs2_unused", C_DEF, 2'd0, 1, 0, 1'b0);
    set_in(1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0);
    step("lu_rs2", C_LU, 2'd0, 2, 0, 1'b0);

    set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
    step("br_over_lu", C_BR, 2'd0, 2, 1, 1'b0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("mw_entry", C_MS, 2'd1, 3, 1, 1'b0);
    step("mw_wait1", C_MS, 2'd1, 4, 1, 1'b0);
    step("mw_wait2", C_MS, 2'd1, 5, 1, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    step("mw_done", C_DEF, 2'd0, 5, 1, 1'b0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("mw2_entry", C_MS, 2'd1, 6, 1, 1'b0);
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    step("mw2_br_exit", C_BR, 2'd0, 6, 2, 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("mw3_entry", C_MS, 2'd1, 7, 2, 1'b0);
    set_in(1, 5'd9, 5'd9, 5'd0, 0, 0, 1, 1);
    step("mw3_lu_exit", C_LU, 2'd0, 8, 2, 1'b0);

    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("to_entry", C_MS, 2'd1, 9, 2, 1'b0);
    step("to_wc0", C_MS, 2'd1, 10, 2, 1'b0);
    step("to_wc1", C_MS, 2'd1, 11, 2, 1'b0);
    step("to_wc2", C_MS, 2'd1, 12, 2, 1'b0);
    step("to_wc3", C_MS, 2'd1, 13, 2, 1'b0);
    step("to_wc4", C_MS, 2'd2, 14, 2, 1'b1);
    set_in(1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1);
    step("err_sticky", C_MS, 2'd2, 14, 2, 1'b1);

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("err_reset", C_RST, 2'd0, 0, 0, 1'b0);
    rst_n = 1'b1;

    set_in(1, 5'd12, 5'd12, 5'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++)
      step("stall_sat", C_LU, 2'd0, (i > 15) ? 15 : i, 0, 1'b0);

    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 17; i++)
      step("flush_sat", C_BR, 2'd0, 15, (i > 15) ? 15 : i, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
